// File: rtl/uart_report_enc.sv
// uart_report_enc
//   Formats a captured time stamp as the ASCII report "HH:MM:SS.CC", with an
//   optional CR LF, and streams it one byte per cycle into a TX FIFO.
//
// Ports
//   clk        system clock, rising edge
//   rst        asynchronous reset, active low
//   req        one-cycle report request (only honoured while idle)
//   hour       hours, binary (5 bits)
//   min        minutes, binary (6 bits)
//   sec        seconds, binary (6 bits)
//   csec       centiseconds, binary (7 bits)
//   fifo_full  TX FIFO full; stalls the stream while high
//   push       FIFO push strobe, one byte per cycle while high
//   push_data  ASCII byte presented with push
//   busy       a report is in progress (SEND or FIN)
//   done       one-cycle pulse on the cycle after the last byte is pushed
module uart_report_enc #(
  parameter int SEND_CRLF = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       req,
  input  logic [4:0] hour,
  input  logic [5:0] min,
  input  logic [5:0] sec,
  input  logic [6:0] csec,
  input  logic       fifo_full,
  output logic       push,
  output logic [7:0] push_data,
  output logic       busy,
  output logic       done
);

  typedef enum logic [1:0] {IDLE, SEND, FIN} state_t;

  // Index of the final byte: 13-byte report with CR LF, 11 bytes without.
  localparam logic [3:0] LAST_IDX = (SEND_CRLF != 0) ? 4'd12 : 4'd10;

  state_t     state_reg, state_next;
  logic [3:0] idx_reg, idx_next;
  logic [4:0] hour_reg;
  logic [5:0] min_reg;
  logic [5:0] sec_reg;
  logic [6:0] csec_reg;
  logic       capture;
  logic [7:0] byte_sel;

  // Two ASCII decimal digits, tens first. Anything above 99 saturates to "99";
  // only csec can actually get there.
  function automatic logic [15:0] two_digits(input logic [6:0] v);
    logic [6:0] c;
    c = (v > 7'd99) ? 7'd99 : v;
    return {8'h30 + 8'(c / 7'd10), 8'h30 + 8'(c % 7'd10)};
  endfunction

  logic [15:0] hh_asc, mm_asc, ss_asc, cc_asc;
  assign hh_asc = two_digits({2'b00, hour_reg});
  assign mm_asc = two_digits({1'b0, min_reg});
  assign ss_asc = two_digits({1'b0, sec_reg});
  assign cc_asc = two_digits(csec_reg);

  // Byte at the current index, always taken from the snapshot.
  always_comb begin
    byte_sel = 8'h00;
    case (idx_reg)
      4'd0:    byte_sel = hh_asc[15:8];
      4'd1:    byte_sel = hh_asc[7:0];
      4'd2:    byte_sel = 8'h3A;          // ':'
      4'd3:    byte_sel = mm_asc[15:8];
      4'd4:    byte_sel = mm_asc[7:0];
      4'd5:    byte_sel = 8'h3A;          // ':'
      4'd6:    byte_sel = ss_asc[15:8];
      4'd7:    byte_sel = ss_asc[7:0];
      4'd8:    byte_sel = 8'h2E;          // '.'
      4'd9:    byte_sel = cc_asc[15:8];
      4'd10:   byte_sel = cc_asc[7:0];
      4'd11:   byte_sel = 8'h0D;          // CR
      4'd12:   byte_sel = 8'h0A;          // LF
      default: byte_sel = 8'h00;
    endcase
  end

  // Next-state and output logic. push follows fifo_full combinationally so a
  // full FIFO stalls the stream in the same cycle it is raised.
  always_comb begin
    state_next = state_reg;
    idx_next   = idx_reg;
    capture    = 1'b0;
    push       = 1'b0;
    push_data  = 8'h00;
    busy       = 1'b0;
    done       = 1'b0;
    case (state_reg)
      IDLE: begin
        if (req) begin
          capture    = 1'b1;
          idx_next   = 4'd0;
          state_next = SEND;
        end
      end
      SEND: begin
        busy      = 1'b1;
        push      = !fifo_full;
        push_data = byte_sel;
        if (!fifo_full) begin
          if (idx_reg == LAST_IDX) state_next = FIN;
          else                     idx_next   = idx_reg + 4'd1;
        end
      end
      FIN: begin
        busy       = 1'b1;
        done       = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg <= IDLE;
      idx_reg   <= 4'd0;
      hour_reg  <= 5'd0;
      min_reg   <= 6'd0;
      sec_reg   <= 6'd0;
      csec_reg  <= 7'd0;
    end else begin
      state_reg <= state_next;
      idx_reg   <= idx_next;
      if (capture) begin
        hour_reg <= hour;
        min_reg  <= min;
        sec_reg  <= sec;
        csec_reg <= csec;
      end
    end
  end

endmodule
